// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared receiver state type, default sizing and counter width helper
package spart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spart_sync2.sv
// rtl/spart_sync2.sv - two-flop synchronizer with a configurable reset value
module spart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART receiver: oversampled 8N1 deserializer with one-deep buffer
// SPART_RX_PARITY_EN adds an even parity bit between the data bits and the stop bit.
module spart_rx
   import spart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_enable,
   input  logic                 rxd,
   input  logic                 read,
   output logic [DATA_BITS-1:0] rx_out,
   output logic                 rda,
   output logic                 framing_err,
   output logic                 overrun,
   output logic                 parity_err
);

   localparam int TW = cnt_w(OVERSAMPLE);
   localparam int BW = cnt_w(DATA_BITS + 1);
   localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_B  = BW'(DATA_BITS - 1);

   logic                 rxs;
   rx_state_t            state_q, state_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] rx_out_q, rx_out_d;
   logic                 rda_q, rda_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 prev_q, prev_d;
   logic                 pend_q, pend_d;
   logic                 fell;
   logic                 done;
`ifdef SPART_RX_PARITY_EN
   logic                 pbit_q, pbit_d;
   logic                 perr_q, perr_d;
`endif

   spart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (rxd),
      .q     (rxs)
   );

   // A falling edge may land between ticks; pend holds it until IDLE's next tick.
   assign fell = prev_q & ~rxs;

   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      bcnt_d   = bcnt_q;
      shreg_d  = shreg_q;
      rx_out_d = rx_out_q;
      rda_d    = rda_q;
      ferr_d   = ferr_q;
      ovr_d    = ovr_q;
      prev_d   = rxs;
      pend_d   = (state_q == IDLE) & ~rxs & (pend_q | fell);
      done     = 1'b0;
`ifdef SPART_RX_PARITY_EN
      pbit_d   = pbit_q;
      perr_d   = perr_q;
`endif
      if (read && rda_q) begin
         rda_d = 1'b0;
         ovr_d = 1'b0;
      end
      if (rx_enable) begin
         case (state_q)
            IDLE: begin
               if ((pend_q || fell) && !rxs) begin
                  state_d = START;
                  tcnt_d  = '0;
               end
            end
            START: begin
               if (tcnt_q == HALF_M1) begin
                  tcnt_d  = '0;
                  bcnt_d  = '0;
                  state_d = rxs ? IDLE : DATA;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            DATA: begin
               if (tcnt_q == FULL_M1) begin
                  tcnt_d  = '0;
                  bcnt_d  = bcnt_q + 1'b1;
                  shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                  if (bcnt_q == LAST_B) begin
`ifdef SPART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
`ifdef SPART_RX_PARITY_EN
            PARITY: begin
               if (tcnt_q == FULL_M1) begin
                  tcnt_d  = '0;
                  pbit_d  = rxs;
                  state_d = STOP;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
`endif
            STOP: begin
               if (tcnt_q == FULL_M1) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (done) begin
         rx_out_d = shreg_q;
         ferr_d   = ~rxs;
         ovr_d    = rda_q & ~read;
         rda_d    = 1'b1;
`ifdef SPART_RX_PARITY_EN
         perr_d   = (^shreg_q) ^ pbit_q;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         tcnt_q   <= '0;
         bcnt_q   <= '0;
         shreg_q  <= '0;
         rx_out_q <= '0;
         rda_q    <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         prev_q   <= 1'b1;
         pend_q   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
         pbit_q   <= 1'b0;
         perr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         bcnt_q   <= bcnt_d;
         shreg_q  <= shreg_d;
         rx_out_q <= rx_out_d;
         rda_q    <= rda_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
         prev_q   <= prev_d;
         pend_q   <= pend_d;
`ifdef SPART_RX_PARITY_EN
         pbit_q   <= pbit_d;
         perr_q   <= perr_d;
`endif
      end
   end

   assign rx_out      = rx_out_q;
   assign rda         = rda_q;
   assign framing_err = ferr_q;
   assign overrun     = ovr_q;
`ifdef SPART_RX_PARITY_EN
   assign parity_err  = perr_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - scoreboard bench for spart_rx; honours SPART_RX_PARITY_EN
module tb_spart_rx;

`ifdef SPART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB     = 10 + PAR;
   localparam int BITCLK = 64;
   localparam int DONE_J = 611 + BITCLK * PAR;

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       ovr;
      logic       perr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_enable = 1'b0;
   logic       rxd = 1'b1;
   logic       read = 1'b0;
   logic [7:0] rx_out;
   logic       rda, framing_err, overrun, parity_err;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];
   logic exp_rda = 1'b0, exp_ovr = 1'b0, exp_fe = 1'b0;
   logic [7:0] last_byte = 8'h00;

   logic [7:0] p_out;
   logic       p_rda, p_fe, p_ovr, p_pe;

   spart_rx dut (
      .clk         (clk),
      .rst         (rst),
      .rx_enable   (rx_enable),
      .rxd         (rxd),
      .read        (read),
      .rx_out      (rx_out),
      .rda         (rda),
      .framing_err (framing_err),
      .overrun     (overrun),
      .parity_err  (parity_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) rx_enable = ((cyc + 1) % 4 == 0);

   task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic check_flags(input string name);
      check({name, "_rda"}, {11'd0, rda}, {11'd0, exp_rda});
      check({name, "_ovr"}, {11'd0, overrun}, {11'd0, exp_ovr});
      check({name, "_fe"}, {11'd0, framing_err}, {11'd0, exp_fe});
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {rx_out, rda, framing_err, overrun, parity_err}, 12'h000);
   endtask

   // A completed byte shows up as rda rising, or as new contents while rda stays set.
   always @(negedge clk) begin
      exp_t e;
      if (rda && (!p_rda || rx_out !== p_out || framing_err !== p_fe ||
                  overrun !== p_ovr || parity_err !== p_pe)) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_byte: got rx_out=%h with no frame outstanding", rx_out);
         end else begin
            e = exp_q.pop_front();
            if ({rx_out, framing_err, overrun, parity_err} !== {e.data, e.fe, e.ovr, e.perr}) begin
               bad++;
               $display("FAIL byte: got data=%h fe=%b ovr=%b perr=%b expected data=%h fe=%b ovr=%b perr=%b",
                        rx_out, framing_err, overrun, parity_err, e.data, e.fe, e.ovr, e.perr);
            end
         end
      end
      p_rda = rda;
      p_out = rx_out;
      p_fe  = framing_err;
      p_ovr = overrun;
      p_pe  = parity_err;
   end

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_read();
      read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      if (exp_rda) begin
         exp_rda = 1'b0;
         exp_ovr = 1'b0;
      end
      @(negedge clk);
   endtask

   // Serialises one frame LSB first; rst_at >= 0 aborts it with a reset at that clk offset.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                             input logic rd_done, input int hold, input int rst_at);
      logic [10:0] bits;
      exp_t        e;
      bits      = '1;
      bits[0]   = 1'b0;
      bits[8:1] = d;
      if (PAR != 0) bits[9] = par_b;
      bits[NB-1] = stop_b;
      while (cyc % 4 != 0) @(negedge clk);
      if (rst_at < 0) begin
         e.data = d;
         e.fe   = ~stop_b;
         e.ovr  = exp_rda & ~rd_done;
         e.perr = (PAR != 0) ? ((^d) ^ par_b) : 1'b0;
         exp_q.push_back(e);
         exp_rda   = 1'b1;
         exp_ovr   = e.ovr;
         exp_fe    = e.fe;
         last_byte = d;
      end
      for (int j = 0; j < NB * BITCLK; j++) begin
         if (j % BITCLK == 0) rxd = bits[j / BITCLK];
         read = rd_done && (j == DONE_J);
         if (j == rst_at) begin
            rst = 1'b0;
            #1;
            exp_rda = 1'b0;
            exp_ovr = 1'b0;
            exp_fe  = 1'b0;
            check_reset_outputs("reset_mid_frame");
         end
         if (rst_at >= 0 && j == rst_at + 8) rst = 1'b1;
         @(negedge clk);
      end
      read = 1'b0;
      repeat (hold) @(negedge clk);
      rxd = 1'b1;
   endtask

   initial begin
      logic [7:0] d;
      logic       stop_b, par_b, rd_done;
      int         hold, gap;

      repeat (6) @(negedge clk);
      check_reset_outputs("reset_state");
      rst = 1'b1;
      idle(40);
      check_reset_outputs("after_reset_idle");

      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, -1);
      idle(64);
      check_flags("a5_delivered");
      do_read();
      check_flags("a5_read");

      while (cyc % 4 != 0) @(negedge clk);
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      idle(128);
      check_flags("false_start");
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0, -1);
      idle(32);
      do_read();

      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3 * BITCLK, -1);
      idle(64);
      check_flags("break_ferr");
      do_read();
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0, -1);
      idle(16);
      check_flags("ferr_cleared");
      do_read();

      send_frame(8'h01, 1'b1, 1'b0, 1'b0, 0, -1);
      send_frame(8'h02, 1'b1, 1'b0, 1'b0, 0, -1);
      idle(16);
      check_flags("overrun_set");
      do_read();
      check_flags("overrun_read");
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, 0, -1);
      send_frame(8'h02, 1'b1, 1'b0, 1'b1, 0, -1);
      idle(16);
      check_flags("read_on_done");
      do_read();

      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0, -1);
      idle(16);
      send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 0, 5 * BITCLK + 32);
      idle(64);
      check_flags("after_abort");
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, 0, -1);
      idle(16);
      check_flags("after_abort_81");
      do_read();

`ifdef SPART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0, -1);
      idle(16);
      check("parity_bad", {11'd0, parity_err}, 12'd1);
      do_read();
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0, -1);
      idle(16);
      check("parity_good", {11'd0, parity_err}, 12'd0);
      do_read();
`endif

      for (int i = 0; i < 24; i++) begin
         d = 8'($urandom);
         if (exp_rda && d == last_byte) d = d ^ 8'h5A;
         stop_b  = ($urandom % 4) != 0;
         par_b   = (PAR != 0) ? 1'($urandom % 2) : ((^d) & 1'b0);
         rd_done = ($urandom % 4) == 0;
         hold    = stop_b ? 0 : BITCLK * $urandom_range(0, 2);
         gap     = 4 * $urandom_range(stop_b ? 0 : 1, 8);
         send_frame(d, stop_b, par_b, rd_done, hold, -1);
         idle(gap);
         if ($urandom % 2 == 0) begin
            do_read();
            check_flags("rand_read");
         end
      end

      idle(200);
      check_flags("final");
      check("queue_drained", 12'(exp_q.size()), 12'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spart_rx.md
# spart_rx

Receive half of the SPART serial port. It converts an asynchronous 8N1 serial stream on `rxd` into parallel bytes, using a 16x-oversampled baud tick from the shared baud generator. Each completed byte is held in a one-deep receive buffer with a receive-data-available (`rda`) flag for the bus interface. It is the line-side peer of the SPART transmitter: a loopback of `txd` into `rxd` must recover every transmitted byte.

## Interface
Parameters:
- `OVERSAMPLE`, 16: `rx_enable` ticks per bit period; even, ≥ 4.
- `DATA_BITS`, 8: payload bits per frame, LSB first.

Ports:
- `clk`  in  1  system clock; the block uses one clock only.
- `rst`  in  1  reset; asynchronous and active-low.
- `rx_enable`  in  1  one-`clk` oversample tick, `OVERSAMPLE` ticks per bit.
- `rxd`  in  1  asynchronous serial input; idles high.
- `read`  in  1  bus read strobe; consumes the buffered byte.
- `rx_out`  out  8  last received byte.
- `rda`  out  1  receive data available.
- `framing_err`  out  1  the stop bit of the last byte sampled low.
- `overrun`  out  1  a byte completed while `rda` was already set.
- `parity_err`  out  1  parity mismatch on the last byte; meaningful only with the macro.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. The rest of the block sees only the synchronized value `rxs`.
- A single ticks counter `tcnt` and a bit counter `bcnt` advance only on `rx_enable` cycles.
- State machine states and transitions:
  - **IDLE**: a start is detected when `rxs` goes 1→0. A previous-value register does the edge detect and resets to 1. On detection, clear `tcnt` and go to START.
  - **START**: when `tcnt` reaches OVERSAMPLE/2−1, re-sample `rxs`.
    - `rxs` = 0: clear `tcnt` and `bcnt`, go to DATA.
    - `rxs` = 1: false start; return to IDLE with no output change.
  - **DATA**: every OVERSAMPLE ticks, shift `rxs` into the shift register MSB-first shift-right, giving LSB-first reception. After DATA_BITS samples, go to PARITY if the macro is defined, otherwise to STOP.
  - **PARITY** (macro only): sample once after OVERSAMPLE ticks, then go to STOP.
  - **STOP**: sample after OVERSAMPLE ticks, then complete the byte and go to IDLE. Completing the byte does the following:
    - `rx_out` ← shift register.
    - `framing_err` ← ~`rxs`.
    - `parity_err` updated (macro only).
    - `overrun` ← `rda` & ~`read`.
    - `rda` ← 1.
- A byte with a framing error is still delivered with `rda` = 1.
- After a low stop bit, IDLE needs `rxs` to return high before the next start. A held-low line (break) therefore yields exactly one byte.
- `read` rules:
  - `read` with `rda` = 1 clears `rda` and `overrun` on that edge.
  - `read` with `rda` = 0 has no effect.
  - `read` coincident with a byte completion: the new byte loads, `rda` stays 1 and `overrun` is not set.
- Overrun: the new byte overwrites `rx_out` and the older byte is lost.
- `rx_enable` held low freezes the state machine. The synchronizer and edge register keep running.

## Timing
- Reset values: `rx_out` = 8'h00; `rda`, `framing_err`, `overrun`, `parity_err` = 0; state = IDLE; synchronizer = 1.
- Reset is asynchronous and may assert mid-frame. The partial frame is discarded and no `rda` is generated.
- `rxd`-to-detection latency is 2 `clk` (synchronizer) plus up to one tick.
- Each bit is sampled OVERSAMPLE/2 ticks after its nominal leading edge, i.e. mid-bit.
- All outputs are registered. `rda` rises on the `clk` edge after the `rx_enable` cycle that samples the stop bit.
- `rda` rises (stop mid-point) ½ bit before the frame ends, so the receiver is back in IDLE in time to detect a back-to-back start bit.

## Configuration
- `SPART_RX_PARITY_EN` defined: the frame carries one parity bit between the data bits and the stop bit. Parity is even: the XOR of the data bits and the parity bit must be 0. `parity_err` is set to 1 on a mismatch and updates at each byte completion.
- `SPART_RX_PARITY_EN` undefined: frames are 8N1 and the PARITY state does not exist. `parity_err` is tied to 0.

## Structure
- Package `spart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - default `OVERSAMPLE` constant;
  - the `$clog2`-derived counter widths.
- Sub-module `spart_sync2`: 2-flop synchronizer with parameterized reset value, reset to 1 here. It is reusable by other SPART blocks.

## Test plan
All scenarios use `rx_enable` every 4 `clk`, so one bit is 64 `clk`.
- Reset, then frame 0xA5 with a valid stop bit -> one `rda` pulse-to-level, `rx_out` = 0xA5, `framing_err` = 0, `overrun` = 0; `read` then clears `rda`.
- `rxd` low for 4 ticks, then high -> no `rda`, state back to IDLE; a following 0x3C frame is received correctly.
- Frame 0x3C with the stop bit low, then the line held low for 3 bit times -> `rx_out` = 0x3C, `framing_err` = 1, exactly one `rda`; the next valid 0x11 frame clears `framing_err`.
- Back-to-back 0x01 and 0x02 with no read -> `overrun` = 1, `rx_out` = 0x02. Repeat with `read` asserted on the completion cycle of 0x02 -> `overrun` = 0, `rda` = 1.
- `rst` asserted during data bit 4 of 0xFF -> all outputs return to reset values immediately; no `rda` for that frame; the next 0x81 is received correctly.
- With `SPART_RX_PARITY_EN`, frame 0x07 sent with parity bit 0 -> `parity_err` = 1; sent with parity bit 1 -> `parity_err` = 0.
